picorv_pcpi_mul: RTL and testbench
==================================

// Module: picorv_pcpi_mul
// PURPOSE
//  PCPI responder: RV32M/RV64M multiply unit (MUL, MULH, MULHSU, MULHU) on picorv_ctrl's PCPI port.
//  Accepts an instruction in one cycle, reports pcpi_wb_async, computes iteratively, then returns
//  the result on the async-writeback (awb) port. Counterpart to the controller's awb consumer.
// PARAMETERS
//  XLEN   32  datapath width (32 or 64)
//  ILEN   32  instruction width
//  STEPS   4  multiplier bits retired per cycle; XLEN % STEPS == 0 required (elaboration error otherwise)
// PORTS
//  clock           in   1     rising-edge clock
//  resetn          in   1     synchronous reset, active low
//  pcpi_valid      in   1     controller presents insn
//  pcpi_insn       in   ILEN  instruction word
//  pcpi_rs1_valid  in   1     rs1 operand available
//  pcpi_rs1_data   in   XLEN  rs1 value
//  pcpi_rs2_valid  in   1     rs2 operand available
//  pcpi_rs2_data   in   XLEN  rs2 value
//  pcpi_wb_valid   in   1     controller permits writeback for this insn
//  pcpi_ready      out  1     insn accepted this cycle
//  pcpi_wb_write   out  1     synchronous result (only with PICORV_PCPI_MUL_SYNC_EN)
//  pcpi_wb_async   out  1     result will follow on awb
//  pcpi_wb_data    out  XLEN  synchronous result data
//  pcpi_br_enable  out  1     tied 0
//  pcpi_br_nextpc  out  XLEN  tied 0
//  awb_valid       out  1     async result valid
//  awb_ready       in   1     controller takes result
//  awb_addr        out  5     destination rd
//  awb_data        out  XLEN  result
// BEHAVIOUR
//  - Match: opcode 0110011, funct7 0000001, funct3 000..011. Non-matching insns: all PCPI outputs 0.
//  - Reset: state IDLE; pcpi_ready, pcpi_wb_*, awb_valid 0; awb_addr/awb_data 0. Reset mid-op drops job.
//  - FSM IDLE -> CALC -> DONE -> IDLE.
//  - IDLE accept (combinational, same cycle):
//    - condition: pcpi_valid & match & rs1_valid & rs2_valid & (rd==0 | pcpi_wb_valid).
//    - rd==0: pcpi_ready=1, no wb flags, stay IDLE.
//    - rd!=0: pcpi_ready=1, pcpi_wb_async=1; latch rd, funct3, operands -> CALC.
//    - condition false: hold outputs 0 and wait (never flag wb while pcpi_wb_valid=0).
//  - CALC: unsigned multiply of operand magnitudes (rs1 abs if funct3 in {MULH,MULHSU}; rs2 abs if MULH),
//    STEPS bits per cycle, XLEN/STEPS cycles; then conditional two's-complement negate of 2*XLEN product
//    in the final CALC cycle. MUL -> low XLEN bits; others -> high XLEN bits.
//  - DONE: awb_valid=1 registered, awb_addr/awb_data stable until awb_ready; handshake -> IDLE next cycle.
//    awb_valid asserted exactly 1+XLEN/STEPS cycles after accept edge (9 for defaults).
//  - While CALC/DONE: new matching insns are not accepted (pcpi_ready=0). Accept of a new insn in the same
//    cycle as the awb handshake is not allowed; the first accept is one cycle later.
//  - Edge: 0*x, x*0, MULH(INT_MIN,INT_MIN)=0x40000000, MULHSU(-1,0xFFFFFFFF)=0xFFFFFFFF all exact.
// CONFIGURATION
//  PICORV_PCPI_MUL_SYNC_EN defined:
//    - No early accept. Insn held in CALC while pcpi_valid stays high.
//    - In DONE: pcpi_ready=1, pcpi_wb_write=1, pcpi_wb_data=result for one cycle, then IDLE.
//    - pcpi_wb_async and awb_valid tied 0.
//    - pcpi_valid dropping in CALC aborts to IDLE.
//  Undefined: async behaviour above; pcpi_wb_write=0 always.
// STRUCTURE
//  - picorv_pkg gains:
//    - OPCODE_OP and FUNCT7_MULDIV constants;
//    - enum mul_op_t {MUL, MULH, MULHSU, MULHU};
//    - typedef mul_state_t.
//  - Sub-module picorv_mul_core: iterative unsigned XLEN x XLEN multiplier.
//    - Inputs: start, a, b. Outputs: done, prod[2*XLEN].
//  - Top-level owns: decode, sign handling, FSM, awb register.
// TESTING
//  1 MUL x5 = 7*6, rd=5, wb_valid=1 -> ready+wb_async at accept; 9 cycles later awb_valid,
//    awb_addr=5, awb_data=42.
//  2 MULH(0x80000000,0x80000000) -> awb_data=0x40000000;
//    MULHU(0xFFFFFFFF,0xFFFFFFFF) -> 0xFFFFFFFE.
//  3 MULHSU(0xFFFFFFFF,2) -> 0xFFFFFFFF; awb_ready held 0 for 5 cycles -> awb_valid/addr/data stable,
//    second MUL stalls until handshake+1.
//  4 rd=0 MUL with wb_valid=0 -> ready same cycle, no async, awb_valid never rises;
//    rd=3 with wb_valid=0 -> ready stays 0.
//  5 resetn=0 during CALC cycle 4 -> next cycle awb_valid=0, IDLE.
//    DIV insn (funct3=100) -> no response.
//  6 SYNC_EN build: MUL 3*-1 -> ready+wb_write with wb_data=0xFFFFFFFD after 9 cycles;
//    pcpi_valid dropped in CALC -> no ready.

Source files
------------

// File: rtl/picorv_pkg.sv
// Shared decode constants and types for the PCPI multiply unit.
package picorv_pkg;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    MUL    = 2'd0,
    MULH   = 2'd1,
    MULHSU = 2'd2,
    MULHU  = 2'd3
  } mul_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/picorv_mul_core.sv
// Iterative unsigned XLEN x XLEN multiplier, STEPS multiplier bits per cycle.
// A start pulse (re)loads the operands; done pulses one cycle after the last step.
module picorv_mul_core #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned STEPS = 4
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic              done,
  output logic [2*XLEN-1:0] prod
);

  localparam int unsigned NSTEP = XLEN / STEPS;
  localparam int unsigned CW    = $clog2(NSTEP + 1);

  logic [2*XLEN-1:0] r_a;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_b;
  logic [CW-1:0]     r_cnt;
  logic              r_busy;
  logic              r_done;
  logic [2*XLEN-1:0] w_sum;

  // Partial-product sum for the STEPS low multiplier bits of this cycle
  always_comb begin
    w_sum = r_acc;
    for (int unsigned i = 0; i < STEPS; i++) begin
      if (r_b[i]) w_sum = w_sum + (r_a << i);
    end
  end

  // Shift-and-add sequencer
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_a    <= '0;
      r_acc  <= '0;
      r_b    <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_a    <= {{XLEN{1'b0}}, a};
        r_b    <= b;
        r_acc  <= '0;
        r_cnt  <= '0;
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_acc <= w_sum;
        r_a   <= r_a << STEPS;
        r_b   <= r_b >> STEPS;
        r_cnt <= r_cnt + CW'(1);
        if (r_cnt == CW'(NSTEP - 1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign done = r_done;
  assign prod = r_acc;

endmodule

// File: rtl/picorv_pcpi_mul.sv
// PCPI multiply responder (MUL/MULH/MULHSU/MULHU) with async writeback port.
// Build option: PICORV_PCPI_MUL_SYNC_EN selects synchronous pcpi_wb_write return
// instead of early accept plus awb delivery.
module picorv_pcpi_mul
  import picorv_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned ILEN  = 32,
  parameter int unsigned STEPS = 4
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            pcpi_valid,
  input  logic [ILEN-1:0] pcpi_insn,
  input  logic            pcpi_rs1_valid,
  input  logic [XLEN-1:0] pcpi_rs1_data,
  input  logic            pcpi_rs2_valid,
  input  logic [XLEN-1:0] pcpi_rs2_data,
  input  logic            pcpi_wb_valid,
  output logic            pcpi_ready,
  output logic            pcpi_wb_write,
  output logic            pcpi_wb_async,
  output logic [XLEN-1:0] pcpi_wb_data,
  output logic            pcpi_br_enable,
  output logic [XLEN-1:0] pcpi_br_nextpc,
  output logic            awb_valid,
  input  logic            awb_ready,
  output logic [4:0]      awb_addr,
  output logic [XLEN-1:0] awb_data
);

  if ((XLEN % STEPS) != 0) begin : g_bad_steps
    $error("picorv_pcpi_mul: XLEN must be a multiple of STEPS");
  end

  mul_state_t        r_state, w_state_nxt;
  mul_op_t           r_op;
  logic [4:0]        r_rd, r_addr;
  logic              r_neg;
  logic [XLEN-1:0]   r_res;

  mul_op_t           w_f3;
  logic [4:0]        w_rd;
  logic              w_match, w_go, w_accept, w_start, w_load;
  logic              w_rs1_neg, w_rs2_neg, w_done;
  logic [XLEN-1:0]   w_a, w_b, w_result;
  logic [2*XLEN-1:0] w_prod, w_prod_s;
  logic              w_unused_insn;

  assign w_unused_insn = &{1'b0, pcpi_insn[24:15]};

  // Decode and operand magnitude selection
  always_comb begin
    w_f3      = mul_op_t'(pcpi_insn[13:12]);
    w_rd      = pcpi_insn[11:7];
    w_match   = (pcpi_insn[6:0] == OPCODE_OP) && (pcpi_insn[31:25] == FUNCT7_MULDIV) && !pcpi_insn[14];
    w_go      = pcpi_valid && w_match && pcpi_rs1_valid && pcpi_rs2_valid;
    w_accept  = w_go && ((w_rd == 5'd0) || pcpi_wb_valid);
    w_rs1_neg = ((w_f3 == MULH) || (w_f3 == MULHSU)) && pcpi_rs1_data[XLEN-1];
    w_rs2_neg = (w_f3 == MULH) && pcpi_rs2_data[XLEN-1];
    w_a       = w_rs1_neg ? -pcpi_rs1_data : pcpi_rs1_data;
    w_b       = w_rs2_neg ? -pcpi_rs2_data : pcpi_rs2_data;
  end

  picorv_mul_core #(.XLEN(XLEN), .STEPS(STEPS)) u_core (
    .clock  (clock),
    .resetn (resetn),
    .start  (w_start),
    .a      (w_a),
    .b      (w_b),
    .done   (w_done),
    .prod   (w_prod)
  );

  // Sign fix-up and half select on the finished product
  always_comb begin
    w_prod_s = r_neg ? -w_prod : w_prod;
    w_result = (r_op == MUL) ? w_prod_s[XLEN-1:0] : w_prod_s[2*XLEN-1:XLEN];
  end

  // Next-state and PCPI handshake outputs
  always_comb begin
    w_state_nxt   = r_state;
    pcpi_ready    = 1'b0;
    pcpi_wb_async = 1'b0;
    pcpi_wb_write = 1'b0;
    w_start       = 1'b0;
    w_load        = 1'b0;
    case (r_state)
      S_IDLE: begin
`ifdef PICORV_PCPI_MUL_SYNC_EN
        if (w_go) begin
          w_start     = 1'b1;
          w_state_nxt = S_CALC;
        end
`else
        if (w_accept) begin
          pcpi_ready = 1'b1;
          if (w_rd != 5'd0) begin
            pcpi_wb_async = 1'b1;
            w_start       = 1'b1;
            w_state_nxt   = S_CALC;
          end
        end
`endif
      end
      S_CALC: begin
`ifdef PICORV_PCPI_MUL_SYNC_EN
        if (!pcpi_valid) begin
          w_state_nxt = S_IDLE;
        end else if (w_done) begin
          w_load      = 1'b1;
          w_state_nxt = S_DONE;
        end
`else
        if (w_done) begin
          w_load      = 1'b1;
          w_state_nxt = S_DONE;
        end
`endif
      end
      S_DONE: begin
`ifdef PICORV_PCPI_MUL_SYNC_EN
        pcpi_ready    = 1'b1;
        pcpi_wb_write = 1'b1;
        w_state_nxt   = S_IDLE;
`else
        if (awb_ready) w_state_nxt = S_IDLE;
`endif
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, job context and result registers
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_op    <= MUL;
      r_rd    <= '0;
      r_neg   <= 1'b0;
      r_addr  <= '0;
      r_res   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_op  <= w_f3;
        r_rd  <= w_rd;
        r_neg <= w_rs1_neg ^ w_rs2_neg;
      end
      if (w_load) begin
        r_res  <= w_result;
        r_addr <= r_rd;
      end
    end
  end

`ifdef PICORV_PCPI_MUL_SYNC_EN
  assign pcpi_wb_data = (r_state == S_DONE) ? r_res : '0;
  assign awb_valid    = 1'b0;
  assign awb_addr     = '0;
  assign awb_data     = '0;
`else
  assign pcpi_wb_data = '0;
  assign awb_valid    = (r_state == S_DONE);
  assign awb_addr     = r_addr;
  assign awb_data     = r_res;
`endif

  assign pcpi_br_enable = 1'b0;
  assign pcpi_br_nextpc = '0;

endmodule

// File: tb/tb_picorv_pcpi_mul.sv
// Directed bench for picorv_pcpi_mul; covers the async build by default and the
// synchronous build when PICORV_PCPI_MUL_SYNC_EN is defined.
module tb_picorv_pcpi_mul;

  localparam logic [2:0] F_MUL = 3'd0, F_MULH = 3'd1, F_MULHSU = 3'd2, F_MULHU = 3'd3, F_DIV = 3'd4;

  logic        clock, resetn;
  logic        pcpi_valid, pcpi_rs1_valid, pcpi_rs2_valid, pcpi_wb_valid;
  logic [31:0] pcpi_insn, pcpi_rs1_data, pcpi_rs2_data;
  logic        pcpi_ready, pcpi_wb_write, pcpi_wb_async, pcpi_br_enable;
  logic [31:0] pcpi_wb_data, pcpi_br_nextpc;
  logic        awb_valid, awb_ready;
  logic [4:0]  awb_addr;
  logic [31:0] awb_data;

  int n_err = 0;
  int n_chk = 0;

  picorv_pcpi_mul #(.XLEN(32), .ILEN(32), .STEPS(4)) dut (
    .clock          (clock),
    .resetn         (resetn),
    .pcpi_valid     (pcpi_valid),
    .pcpi_insn      (pcpi_insn),
    .pcpi_rs1_valid (pcpi_rs1_valid),
    .pcpi_rs1_data  (pcpi_rs1_data),
    .pcpi_rs2_valid (pcpi_rs2_valid),
    .pcpi_rs2_data  (pcpi_rs2_data),
    .pcpi_wb_valid  (pcpi_wb_valid),
    .pcpi_ready     (pcpi_ready),
    .pcpi_wb_write  (pcpi_wb_write),
    .pcpi_wb_async  (pcpi_wb_async),
    .pcpi_wb_data   (pcpi_wb_data),
    .pcpi_br_enable (pcpi_br_enable),
    .pcpi_br_nextpc (pcpi_br_nextpc),
    .awb_valid      (awb_valid),
    .awb_ready      (awb_ready),
    .awb_addr       (awb_addr),
    .awb_data       (awb_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] rd);
    return {7'b0000001, 5'd2, 5'd1, f3, rd, 7'b0110011};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] a, input logic [31:0] b, input logic wbv);
    @(negedge clock);
    pcpi_valid     = 1'b1;
    pcpi_insn      = mk(f3, rd);
    pcpi_rs1_data  = a;
    pcpi_rs2_data  = b;
    pcpi_rs1_valid = 1'b1;
    pcpi_rs2_valid = 1'b1;
    pcpi_wb_valid  = wbv;
    #1;
  endtask

  task automatic drop();
    pcpi_valid    = 1'b0;
    pcpi_wb_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until the flag is seen at a negedge
  task automatic wait_flag(input string tag, input bit use_ready);
    int cnt = 0;
    while (cnt < 20) begin
      @(posedge clock);
      cnt++;
      @(negedge clock);
      if (use_ready ? pcpi_ready : awb_valid) break;
    end
    chk(tag, 32'(cnt), 32'd9);
  endtask

  task automatic handshake();
    @(negedge clock);
    awb_ready = 1'b1;
    @(posedge clock);
    #1 awb_ready = 1'b0;
  endtask

  task automatic async_op(input string tag, input logic [2:0] f3, input logic [4:0] rd,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    drive(f3, rd, a, b, 1'b1);
    chk({tag, " ready"}, 32'(pcpi_ready), 32'd1);
    chk({tag, " async"}, 32'(pcpi_wb_async), 32'd1);
    @(posedge clock);
    #1 drop();
    wait_flag({tag, " latency"}, 1'b0);
    chk({tag, " addr"}, 32'(awb_addr), 32'(rd));
    chk({tag, " data"}, awb_data, exp);
    handshake();
    @(negedge clock);
    chk({tag, " valid clr"}, 32'(awb_valid), 32'd0);
  endtask

  initial begin
    int bad;
    resetn = 1'b0; awb_ready = 1'b0;
    pcpi_valid = 1'b0; pcpi_insn = '0; pcpi_rs1_valid = 1'b0; pcpi_rs2_valid = 1'b0;
    pcpi_rs1_data = '0; pcpi_rs2_data = '0; pcpi_wb_valid = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst ready", 32'(pcpi_ready), 32'd0);
    chk("rst async", 32'(pcpi_wb_async), 32'd0);
    chk("rst write", 32'(pcpi_wb_write), 32'd0);
    chk("rst awb_valid", 32'(awb_valid), 32'd0);
    chk("rst awb_addr", 32'(awb_addr), 32'd0);
    chk("rst awb_data", awb_data, 32'd0);
    resetn = 1'b1;

`ifdef PICORV_PCPI_MUL_SYNC_EN
    drive(F_MUL, 5'd5, 32'd3, 32'hFFFF_FFFF, 1'b1);
    chk("s1 no early ready", 32'(pcpi_ready), 32'd0);
    @(posedge clock);
    wait_flag("s1 latency", 1'b1);
    chk("s1 wb_write", 32'(pcpi_wb_write), 32'd1);
    chk("s1 wb_data", pcpi_wb_data, 32'hFFFF_FFFD);
    chk("s1 async", 32'(pcpi_wb_async), 32'd0);
    chk("s1 awb_valid", 32'(awb_valid), 32'd0);
    @(posedge clock);
    #1 drop();
    chk("s1 ready clr", 32'(pcpi_ready), 32'd0);

    drive(F_MUL, 5'd5, 32'd3, 32'd4, 1'b1);
    repeat (4) @(posedge clock);
    #1 drop();
    bad = 0;
    repeat (14) begin
      @(negedge clock);
      if (pcpi_ready || pcpi_wb_write) bad++;
    end
    chk("s2 abort no ready", 32'(bad), 32'd0);

    drive(F_MULHU, 5'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    @(posedge clock);
    wait_flag("s3 latency", 1'b1);
    chk("s3 wb_data", pcpi_wb_data, 32'hFFFF_FFFE);
    @(posedge clock);
    #1 drop();
`else
    async_op("t1 mul", F_MUL, 5'd5, 32'd7, 32'd6, 32'd42);
    async_op("t2 mulh min", F_MULH, 5'd10, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    async_op("t2 mulhu", F_MULHU, 5'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    async_op("t2 mulhsu", F_MULHSU, 5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    async_op("t2 0*x", F_MUL, 5'd13, 32'd0, 32'h1234_5678, 32'd0);
    async_op("t2 x*0", F_MUL, 5'd14, 32'hDEAD_BEEF, 32'd0, 32'd0);
    async_op("t2 mul lo", F_MUL, 5'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1);
    async_op("t2 mulh neg", F_MULH, 5'd16, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF);

    drive(F_MULHSU, 5'd9, 32'hFFFF_FFFF, 32'd2, 1'b1);
    chk("t3 ready", 32'(pcpi_ready), 32'd1);
    @(posedge clock);
    #1 drop();
    wait_flag("t3 latency", 1'b0);
    chk("t3 addr", 32'(awb_addr), 32'd9);
    chk("t3 data", awb_data, 32'hFFFF_FFFF);
    pcpi_valid = 1'b1; pcpi_insn = mk(F_MUL, 5'd6);
    pcpi_rs1_data = 32'd5; pcpi_rs2_data = 32'd8; pcpi_wb_valid = 1'b1;
    bad = 0;
    repeat (5) begin
      @(posedge clock);
      @(negedge clock);
      if (!(awb_valid === 1'b1 && awb_addr === 5'd9 && awb_data === 32'hFFFF_FFFF && pcpi_ready === 1'b0))
        bad++;
    end
    chk("t3 stall stable", 32'(bad), 32'd0);
    awb_ready = 1'b1;
    #1 chk("t3 no accept at handshake", 32'(pcpi_ready), 32'd0);
    @(posedge clock);
    #1 awb_ready = 1'b0;
    chk("t3 accept after handshake", 32'(pcpi_ready), 32'd1);
    chk("t3 async after handshake", 32'(pcpi_wb_async), 32'd1);
    @(posedge clock);
    #1 drop();
    wait_flag("t3b latency", 1'b0);
    chk("t3b addr", 32'(awb_addr), 32'd6);
    chk("t3b data", awb_data, 32'd40);
    handshake();

    drive(F_MUL, 5'd0, 32'd3, 32'd4, 1'b0);
    chk("t4 rd0 ready", 32'(pcpi_ready), 32'd1);
    chk("t4 rd0 async", 32'(pcpi_wb_async), 32'd0);
    @(posedge clock);
    #1 drop();
    bad = 0;
    repeat (12) begin
      @(negedge clock);
      if (awb_valid) bad++;
    end
    chk("t4 rd0 no awb", 32'(bad), 32'd0);
    drive(F_MUL, 5'd3, 32'd3, 32'd4, 1'b0);
    bad = 0;
    repeat (4) begin
      if (pcpi_ready || pcpi_wb_async) bad++;
      @(posedge clock);
      #1;
    end
    drop();
    chk("t4 no wb_valid no ready", 32'(bad), 32'd0);

    drive(F_MUL, 5'd7, 32'd5, 32'd5, 1'b1);
    @(posedge clock);
    #1 drop();
    repeat (4) @(posedge clock);
    @(negedge clock);
    resetn = 1'b0;
    @(posedge clock);
    #1 resetn = 1'b1;
    chk("t5 rst awb_valid", 32'(awb_valid), 32'd0);
    bad = 0;
    repeat (12) begin
      @(negedge clock);
      if (awb_valid) bad++;
    end
    chk("t5 job dropped", 32'(bad), 32'd0);
    async_op("t5 after rst", F_MUL, 5'd1, 32'd2, 32'd3, 32'd6);

    drive(F_DIV, 5'd4, 32'd6, 32'd3, 1'b1);
    bad = 0;
    repeat (3) begin
      if (pcpi_ready || pcpi_wb_async || pcpi_wb_write) bad++;
      @(posedge clock);
      #1;
    end
    drop();
    chk("t5 div ignored", 32'(bad), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
